// File: rtl/alerta_pkg.sv
// Shared definitions for the alert generator: FSM state encoding, alert
// level codes and a saturating subtraction used to lower thresholds.
package alerta_pkg;

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        SOLICITAR = 2'd1,
        COMPARAR  = 2'd2,
        DECIDIR   = 2'd3
    } estado_t;

    localparam logic [1:0] NIVEL_NINGUNO = 2'b00;
    localparam logic [1:0] NIVEL_DEBIL   = 2'b10;
    localparam logic [1:0] NIVEL_FUERTE  = 2'b11;

    // a - b, clamped at zero so a lowered threshold never wraps around
    function automatic int unsigned resta_saturada(input int unsigned a,
                                                   input int unsigned b);
        return (a >= b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/clasificador_nivel.sv
// Combinational level classifier. Maps a sensor sample to an alert level
// using the weak/strong thresholds. With HISTERESIS_EN defined, the
// downward thresholds are lowered by HIST while the current alert is
// already at or above that level, so a reading hovering near a threshold
// does not make the alert chatter.
module clasificador_nivel
    import alerta_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int HIST   = 10
) (
    input  logic [DATA_W-1:0] muestra,
    input  logic [1:0]        alerta,
    input  logic [DATA_W-1:0] umbral_debil,
    input  logic [DATA_W-1:0] umbral_fuerte,
    output logic [1:0]        nivel
);

`ifdef HISTERESIS_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic [DATA_W-1:0] fuerte_bajo;
    logic [DATA_W-1:0] debil_bajo;
    logic [DATA_W-1:0] fuerte_ef;
    logic [DATA_W-1:0] debil_ef;

    // Pick the effective thresholds for the current alert, then classify
    always_comb begin
        fuerte_bajo = DATA_W'(resta_saturada(32'(umbral_fuerte), HIST));
        debil_bajo  = DATA_W'(resta_saturada(32'(umbral_debil), HIST));
        fuerte_ef   = umbral_fuerte;
        debil_ef    = umbral_debil;
        if (HIST_ON && (alerta == NIVEL_FUERTE)) begin
            fuerte_ef = fuerte_bajo;
        end
        if (HIST_ON && (alerta != NIVEL_NINGUNO)) begin
            debil_ef = debil_bajo;
        end
        if (muestra >= fuerte_ef) begin
            nivel = NIVEL_FUERTE;
        end else if (muestra >= debil_ef) begin
            nivel = NIVEL_DEBIL;
        end else begin
            nivel = NIVEL_NINGUNO;
        end
    end

endmodule

// File: rtl/generador_alerta.sv
// Periodic sensor sampler and alert generator. Requests a reading every
// PERIODO cycles, waits up to TIMEOUT cycles for it, classifies it and only
// changes Alerta after CONFIRMAR consecutive agreeing samples. A one-cycle
// Activar_Decidir strobe follows every successful sample.
// Optional feature: define HISTERESIS_EN to enable threshold hysteresis.
module generador_alerta
    import alerta_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int UMBRAL_DEBIL  = 100,
    parameter int UMBRAL_FUERTE = 200,
    parameter int PERIODO       = 10,
    parameter int CONFIRMAR     = 3,
    parameter int TIMEOUT       = 16,
    parameter int HIST          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Dato,
    input  logic              Dato_Valido,
    output logic              Solicitar_Dato,
    output logic [1:0]        Alerta,
    output logic              Activar_Decidir,
    output logic              Error_Sensor
);

    localparam int PER_W  = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CONF_W = $clog2(CONFIRMAR + 1);

    localparam logic [DATA_W-1:0] UMB_DEBIL  = DATA_W'(UMBRAL_DEBIL);
    localparam logic [DATA_W-1:0] UMB_FUERTE = DATA_W'(UMBRAL_FUERTE);

    estado_t             estado;
    logic [PER_W-1:0]    cnt_periodo;
    logic [TO_W-1:0]     cnt_timeout;
    logic [CONF_W-1:0]   cnt_confirmar;
    logic [CONF_W-1:0]   cnt_siguiente;
    logic [DATA_W-1:0]   muestra;
    logic [1:0]          candidato;
    logic [1:0]          nivel;

    clasificador_nivel #(
        .DATA_W (DATA_W),
        .HIST   (HIST)
    ) u_clasificador (
        .muestra       (muestra),
        .alerta        (Alerta),
        .umbral_debil  (UMB_DEBIL),
        .umbral_fuerte (UMB_FUERTE),
        .nivel         (nivel)
    );

    assign Solicitar_Dato  = (estado == SOLICITAR);
    assign Activar_Decidir = (estado == DECIDIR);

    // Confirmation count this sample would produce if it differs from Alerta
    always_comb begin
        cnt_siguiente = CONF_W'(1);
        if (nivel == candidato) begin
            cnt_siguiente = cnt_confirmar + CONF_W'(1);
        end
    end

    // Main sequencer: period wait, request/timeout, confirmation, strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            estado        <= ESPERA;
            cnt_periodo   <= '0;
            cnt_timeout   <= '0;
            cnt_confirmar <= '0;
            muestra       <= '0;
            candidato     <= NIVEL_NINGUNO;
            Alerta        <= NIVEL_NINGUNO;
            Error_Sensor  <= 1'b0;
        end else begin
            case (estado)
                ESPERA: begin
                    if (cnt_periodo == PER_W'(PERIODO - 1)) begin
                        cnt_periodo <= '0;
                        estado      <= SOLICITAR;
                    end else begin
                        cnt_periodo <= cnt_periodo + PER_W'(1);
                    end
                end
                SOLICITAR: begin
                    if (Dato_Valido) begin
                        muestra      <= Dato;
                        Error_Sensor <= 1'b0;
                        cnt_timeout  <= '0;
                        estado       <= COMPARAR;
                    end else if (cnt_timeout == TO_W'(TIMEOUT - 1)) begin
                        Error_Sensor <= 1'b1;
                        cnt_timeout  <= '0;
                        estado       <= ESPERA;
                    end else begin
                        cnt_timeout <= cnt_timeout + TO_W'(1);
                    end
                end
                COMPARAR: begin
                    if (nivel == Alerta) begin
                        cnt_confirmar <= '0;
                    end else begin
                        candidato <= nivel;
                        if (cnt_siguiente == CONF_W'(CONFIRMAR)) begin
                            Alerta        <= nivel;
                            cnt_confirmar <= '0;
                        end else begin
                            cnt_confirmar <= cnt_siguiente;
                        end
                    end
                    estado <= DECIDIR;
                end
                DECIDIR: begin
                    estado <= ESPERA;
                end
                default: begin
                    estado <= ESPERA;
                end
            endcase
        end
    end

endmodule
